// File: rtl/apb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : apb_irq_ctrl
// Brief   : APB-programmable interrupt controller. It captures level or
//           rising-edge sources into pending bits, masks them, picks the
//           lowest index and hands it to the core over a req/ack handshake.
// Revision: 1.0 - initial release
// ============================================================================
module apb_irq_ctrl #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_IRQ        = 32
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NUM_IRQ-1:0]        irq_src,
    output logic                      irq_req,
    output logic [4:0]                irq_id,
    input  logic                      irq_ack
);

    localparam logic [3:0] c_OFF_MASK     = 4'h0;
    localparam logic [3:0] c_OFF_PENDING  = 4'h1;
    localparam logic [3:0] c_OFF_PEND_SET = 4'h2;
    localparam logic [3:0] c_OFF_PEND_CLR = 4'h3;
    localparam logic [3:0] c_OFF_EDGE     = 4'h4;
    localparam logic [3:0] c_OFF_ACTIVE   = 4'h5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_IRQ-1:0]   r_mask;
    logic [NUM_IRQ-1:0]   r_pending;
    logic [NUM_IRQ-1:0]   r_edge;
    logic [NUM_IRQ-1:0]   r_src_q;
    logic                 r_req;
    logic [4:0]           r_id;

    logic                 w_wr;
    logic [3:0]           w_off;
    logic [NUM_IRQ-1:0]   w_wdata;
    logic [NUM_IRQ-1:0]   w_src_set;
    logic [NUM_IRQ-1:0]   w_set;
    logic [NUM_IRQ-1:0]   w_clr;
    logic [NUM_IRQ-1:0]   w_ack_clr;
    logic [NUM_IRQ-1:0]   w_masked;
    logic                 w_any;
    logic [4:0]           w_enc;
    logic                 w_ack;
    logic                 w_unused;

    assign w_wr     = PSEL && PENABLE && PWRITE;
    assign w_off    = PADDR[5:2];
    assign w_wdata  = PWDATA[NUM_IRQ-1:0];
    assign w_unused = ^{PADDR, PWDATA};

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;
    assign irq_req = r_req;
    assign irq_id  = r_id;

    // Ack only counts while a request is actually outstanding
    assign w_ack = irq_ack && r_req;

    always_comb begin
        w_ack_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_ack_clr[i] = w_ack && (r_id == 5'(i));
        end
    end

    assign w_src_set = (r_edge & irq_src & ~r_src_q) | (~r_edge & irq_src);
    assign w_set     = w_src_set
                     | ((w_wr && w_off == c_OFF_PEND_SET) ? w_wdata : '0);
    assign w_clr     = w_ack_clr
                     | ((w_wr && w_off == c_OFF_PEND_CLR) ? w_wdata : '0);

    assign w_masked = r_pending & r_mask;
    assign w_any    = |w_masked;

    // Scan downwards so the lowest set index is the one left in w_enc
    always_comb begin
        w_enc = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                w_enc = 5'(i);
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_mask    <= '0;
            r_edge    <= '0;
            r_pending <= '0;
            r_src_q   <= '0;
        end else begin
            r_src_q   <= irq_src;
            r_pending <= w_set | (r_pending & ~w_clr);
            if (w_wr && w_off == c_OFF_MASK) begin
                r_mask <= w_wdata;
            end
            if (w_wr && w_off == c_OFF_EDGE) begin
                r_edge <= w_wdata;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_any) begin
                r_req <= 1'b1;
                r_id  <= w_enc;
            end else if (r_state == ST_REQ && irq_ack) begin
                r_req <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any)   w_state_nxt = ST_REQ;
            ST_REQ:  if (irq_ack) w_state_nxt = ST_GAP;
            ST_GAP:               w_state_nxt = ST_IDLE;
            default:              w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        PRDATA = '0;
        case (w_off)
            c_OFF_MASK:    PRDATA[NUM_IRQ-1:0] = r_mask;
            c_OFF_PENDING: PRDATA[NUM_IRQ-1:0] = r_pending;
            c_OFF_EDGE:    PRDATA[NUM_IRQ-1:0] = r_edge;
            c_OFF_ACTIVE:  PRDATA = {r_req, 26'b0, r_id};
            default:       PRDATA = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_apb_irq_ctrl
// Brief   : Directed self-checking bench for apb_irq_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_apb_irq_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [11:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PWRITE = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] irq_src = '0;
    logic        irq_req;
    logic [4:0]  irq_id;
    logic        irq_ack = 1'b0;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] rdv;

    apb_irq_ctrl #(.APB_ADDR_WIDTH(12), .NUM_IRQ(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .irq_src(irq_src),
        .irq_req(irq_req), .irq_id(irq_id), .irq_ack(irq_ack)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d);
        PADDR = {6'b0, off, 2'b00};
        PWDATA = d;
        PWRITE = 1'b1;
        PSEL = 1'b1;
        PENABLE = 1'b0;
        tick();
        PENABLE = 1'b1;
        tick();
        PSEL = 1'b0;
        PENABLE = 1'b0;
        PWRITE = 1'b0;
    endtask

    task automatic rd(input logic [3:0] off, output logic [31:0] d);
        PADDR = {6'b0, off, 2'b00};
        PWRITE = 1'b0;
        PSEL = 1'b1;
        #1;
        d = PRDATA;
        PSEL = 1'b0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'd0, 32'd1);
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        tick();
        HRESET = 1'b0;
        check("rst_req", {31'b0, irq_req}, 32'h0);
        check("rst_id", {27'b0, irq_id}, 32'h0);
        rd(4'h0, rdv); check("rst_mask", rdv, 32'h0);
        rd(4'h1, rdv); check("rst_pending", rdv, 32'h0);
        check("pready", {31'b0, PREADY}, 32'h1);
        check("pslverr", {31'b0, PSLVERR}, 32'h0);

        // Edge source 0, single-cycle pulse
        wr(4'h0, 32'h1);
        wr(4'h4, 32'h1);
        irq_src = 32'h1;
        tick();
        irq_src = 32'h0;
        rd(4'h1, rdv); check("t1_pending", rdv, 32'h1);
        check("t1_req_early", {31'b0, irq_req}, 32'h0);
        tick();
        check("t1_req", {31'b0, irq_req}, 32'h1);
        check("t1_id", {27'b0, irq_id}, 32'h0);
        ack();
        check("t1_req_ack", {31'b0, irq_req}, 32'h0);
        rd(4'h1, rdv); check("t1_pending_ack", rdv, 32'h0);
        tick(); tick();

        // Two simultaneous edges: lowest index first
        wr(4'h0, 32'hFFFF_FFFF);
        wr(4'h4, 32'hFFFF_FFFF);
        irq_src = 32'h28;
        tick();
        rd(4'h1, rdv); check("t2_pending", rdv, 32'h28);
        tick();
        check("t2_id_a", {27'b0, irq_id}, 32'd3);
        rd(4'h5, rdv); check("t2_active_a", rdv, 32'h8000_0003);
        ack();
        rd(4'h1, rdv); check("t2_pending_ack", rdv, 32'h20);
        tick();
        check("t2_gap", {31'b0, irq_req}, 32'h0);
        tick();
        check("t2_req_b", {31'b0, irq_req}, 32'h1);
        rd(4'h5, rdv); check("t2_active_b", rdv, 32'h8000_0005);
        ack();
        irq_src = 32'h0;
        tick(); tick();
        rd(4'h1, rdv); check("t2_pending_end", rdv, 32'h0);

        // Level source 7 held high re-requests two cycles after ack
        wr(4'h4, 32'h0);
        wr(4'h0, 32'h80);
        irq_src = 32'h80;
        tick();
        tick();
        check("t3_id", {27'b0, irq_id}, 32'd7);
        check("t3_req", {31'b0, irq_req}, 32'h1);
        ack();
        check("t3_req_ack", {31'b0, irq_req}, 32'h0);
        rd(4'h1, rdv); check("t3_pending_held", rdv, 32'h80);
        tick();
        check("t3_req_gap", {31'b0, irq_req}, 32'h0);
        tick();
        check("t3_rereq", {31'b0, irq_req}, 32'h1);
        irq_src = 32'h0;
        ack();
        rd(4'h1, rdv); check("t3_pending_clr", rdv, 32'h0);
        tick(); tick();

        // Software set with mask closed, then open mask
        wr(4'h0, 32'h0);
        wr(4'h2, 32'h10);
        rd(4'h1, rdv); check("t4_pending", rdv, 32'h10);
        tick();
        check("t4_noreq", {31'b0, irq_req}, 32'h0);
        wr(4'h0, 32'h10);
        check("t4_req_early", {31'b0, irq_req}, 32'h0);
        tick();
        check("t4_req", {31'b0, irq_req}, 32'h1);
        check("t4_id", {27'b0, irq_id}, 32'd4);
        ack();
        rd(4'h1, rdv); check("t4_pending_ack", rdv, 32'h0);
        tick(); tick();

        // Request is held even when its pending bit is cleared and masked off
        wr(4'h2, 32'h4);
        wr(4'h0, 32'h4);
        tick();
        check("t5_id", {27'b0, irq_id}, 32'd2);
        wr(4'h3, 32'h4);
        wr(4'h0, 32'h0);
        check("t5_req_hold", {31'b0, irq_req}, 32'h1);
        check("t5_id_hold", {27'b0, irq_id}, 32'd2);
        rd(4'h1, rdv); check("t5_pending_clr", rdv, 32'h0);
        ack();
        check("t5_req_ack", {31'b0, irq_req}, 32'h0);
        rd(4'h1, rdv); check("t5_pending_ack", rdv, 32'h0);
        tick(); tick();

        // Set wins over a concurrent software clear; unmapped offsets
        irq_src = 32'h200;
        wr(4'h3, 32'h200);
        rd(4'h1, rdv); check("setwins_pending", rdv, 32'h200);
        irq_src = 32'h0;
        wr(4'h3, 32'h200);
        rd(4'h1, rdv); check("clr_pending", rdv, 32'h0);
        wr(4'h7, 32'hDEAD_BEEF);
        rd(4'h7, rdv); check("unmapped_rd", rdv, 32'h0);
        rd(4'h2, rdv); check("wo_rd", rdv, 32'h0);

        // Reset while requesting
        wr(4'h0, 32'hF);
        wr(4'h2, 32'h2);
        tick();
        check("t6_req", {31'b0, irq_req}, 32'h1);
        check("t6_id", {27'b0, irq_id}, 32'd1);
        HRESET = 1'b1;
        tick();
        check("t6_rst_req", {31'b0, irq_req}, 32'h0);
        rd(4'h0, rdv); check("t6_mask", rdv, 32'h0);
        rd(4'h1, rdv); check("t6_pending", rdv, 32'h0);
        rd(4'h4, rdv); check("t6_edge", rdv, 32'h0);
        rd(4'h5, rdv); check("t6_active", rdv, 32'h0);
        HRESET = 1'b0;
        tick(); tick(); tick();
        check("t6_noreq", {31'b0, irq_req}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
